// File: rtl/ibex_prefetch_ctrl_if.sv
// Fetch request controller bus: control, instruction memory port, FIFO push.
// master = controller side, slave = core/memory/FIFO side; err pair with IBEX_PREFETCH_ERR_EN.
interface ibex_prefetch_ctrl_if;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        busy_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        fifo_ready_i;
  logic        fifo_valid_o;
  logic [31:0] fifo_rdata_o;
  logic [31:0] fifo_addr_o;
  logic        fifo_clear_o;
`ifdef IBEX_PREFETCH_ERR_EN
  logic        instr_err_i;
  logic        fifo_err_o;
`endif

  modport master (
`ifdef IBEX_PREFETCH_ERR_EN
    input  instr_err_i,
    output fifo_err_o,
`endif
    input  req_i,
    input  branch_i,
    input  addr_i,
    output busy_o,
    output instr_req_o,
    output instr_addr_o,
    input  instr_gnt_i,
    input  instr_rvalid_i,
    input  instr_rdata_i,
    input  fifo_ready_i,
    output fifo_valid_o,
    output fifo_rdata_o,
    output fifo_addr_o,
    output fifo_clear_o
  );

  modport slave (
`ifdef IBEX_PREFETCH_ERR_EN
    output instr_err_i,
    input  fifo_err_o,
`endif
    output req_i,
    output branch_i,
    output addr_i,
    input  busy_o,
    input  instr_req_o,
    input  instr_addr_o,
    output instr_gnt_i,
    output instr_rvalid_i,
    output instr_rdata_i,
    output fifo_ready_i,
    input  fifo_valid_o,
    input  fifo_rdata_o,
    input  fifo_addr_o,
    input  fifo_clear_o
  );
endinterface

// File: rtl/ibex_prefetch_ctrl.sv
// Single-outstanding instruction fetch controller feeding the fetch FIFO.
// Ports: clk, rst (async, high), bus (master). Option: IBEX_PREFETCH_ERR_EN.
module ibex_prefetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input logic           clk,
  input logic           rst,
  ibex_prefetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_ABORTED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic        abort_q, abort_d;
  logic [31:0] nxt, inc_addr, req_addr;
  logic        issue_ok, issue, push, req;
  logic        err_blk, rsp_err;

`ifdef IBEX_PREFETCH_ERR_EN
  logic err_q, err_d;
  assign err_blk = err_q;
  assign rsp_err = bus.instr_err_i;
  assign bus.fifo_err_o = push & rsp_err;

  always_comb begin
    err_d = err_q;
    if (bus.branch_i) err_d = 1'b0;
    if (push & rsp_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign err_blk = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // A branch may always issue: the FIFO is being cleared.
  assign issue_ok = ~rst & bus.req_i
                  & (bus.branch_i | (bus.fifo_ready_i & ~err_blk));
  assign inc_addr = {rsp_addr_q[31:2] + 30'd1, 2'b00};

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = bus.branch_i ? bus.addr_i : fetch_addr_q;
    rsp_addr_d   = rsp_addr_q;
    abort_d      = abort_q;
    nxt          = bus.branch_i ? bus.addr_i : fetch_addr_q;
    issue        = 1'b0;
    push         = 1'b0;
    req          = 1'b0;
    req_addr     = 32'h0;
    unique case (state_q)
      IDLE: begin
        issue = issue_ok;
      end
      WAIT_GNT: begin
        req      = 1'b1;
        req_addr = {rsp_addr_q[31:2], 2'b00};
        if (bus.branch_i) abort_d = 1'b1;
        if (bus.instr_gnt_i) begin
          abort_d = 1'b0;
          state_d = (abort_q | bus.branch_i) ? WAIT_ABORTED
                                             : WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        if (bus.instr_rvalid_i) begin
          state_d = IDLE;
          if (!bus.branch_i) begin
            push         = 1'b1;
            fetch_addr_d = inc_addr;
            nxt          = inc_addr;
            issue        = issue_ok & ~rsp_err;
          end else begin
            issue = issue_ok;
          end
        end else if (bus.branch_i) begin
          state_d = WAIT_ABORTED;
        end
      end
      WAIT_ABORTED: begin
        if (bus.instr_rvalid_i) begin
          state_d = IDLE;
          issue   = issue_ok;
        end
      end
      default: state_d = IDLE;
    endcase
    // rsp_addr keeps bit 1 so an unaligned target is reported as-is.
    if (issue) begin
      req        = 1'b1;
      req_addr   = {nxt[31:2], 2'b00};
      rsp_addr_d = nxt;
      abort_d    = 1'b0;
      state_d    = bus.instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= BOOT_ADDR;
      rsp_addr_q   <= 32'h0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      rsp_addr_q   <= rsp_addr_d;
      abort_q      <= abort_d;
    end
  end

  assign bus.busy_o       = (state_q != IDLE);
  assign bus.instr_req_o  = req;
  assign bus.instr_addr_o = req_addr;
  assign bus.fifo_valid_o = push;
  assign bus.fifo_rdata_o = bus.instr_rdata_i;
  assign bus.fifo_addr_o  = rsp_addr_q;
  assign bus.fifo_clear_o = bus.branch_i;

endmodule

// File: tb/tb_ibex_prefetch_ctrl.sv
// Directed bench for ibex_prefetch_ctrl with a transaction-level reference model.
// Model tracks pending/in-flight requests; every cycle is compared on the falling edge.
module tb_ibex_prefetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ibex_prefetch_ctrl_if bus();

  ibex_prefetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a request waiting for grant (pend),
  // a request waiting for its response (fly), and the fetch pointer.
  bit          pend = 0, fly = 0, pstale = 0, fstale = 0;
  logic [31:0] paddr = 0, faddr = 0, pc = 32'h80;

  logic        m_push, m_free, m_new;
  logic [31:0] m_tgt, e_addr;
  logic        e_req, e_busy;

  always_comb begin
    m_push = !rst && fly && bus.instr_rvalid_i && !fstale && !bus.branch_i;
    m_free = !pend && (!fly || bus.instr_rvalid_i);
    m_new  = !rst && m_free && bus.req_i
             && (bus.branch_i || bus.fifo_ready_i);
    if (bus.branch_i)  m_tgt = bus.addr_i;
    else if (m_push)   m_tgt = (faddr & 32'hFFFF_FFFC) + 32'd4;
    else               m_tgt = pc;
    e_req  = !rst && (pend || m_new);
    e_busy = !rst && (pend || fly);
    if (!e_req)    e_addr = 32'h0;
    else if (pend) e_addr = paddr & 32'hFFFF_FFFC;
    else           e_addr = m_tgt & 32'hFFFF_FFFC;
  end

  always @(posedge clk) begin
    bit          n_pend, n_fly, n_ps, n_fs;
    logic [31:0] n_pa, n_fa, n_pc;
    n_pend = pend; n_fly = fly; n_ps = pstale; n_fs = fstale;
    n_pa = paddr; n_fa = faddr; n_pc = pc;
    if (rst) begin
      n_pend = 0; n_fly = 0; n_ps = 0; n_fs = 0; n_pc = 32'h80;
    end else begin
      if (bus.branch_i) n_pc = bus.addr_i;
      if (m_push) n_pc = (faddr & 32'hFFFF_FFFC) + 32'd4;
      if (fly && bus.instr_rvalid_i) n_fly = 0;
      if (fly && !bus.instr_rvalid_i && bus.branch_i) n_fs = 1;
      if (pend && bus.branch_i) n_ps = 1;
      if (pend && bus.instr_gnt_i) begin
        n_pend = 0; n_fly = 1; n_fa = paddr; n_fs = n_ps;
      end
      if (m_new) begin
        if (bus.instr_gnt_i) begin
          n_fly = 1; n_fa = m_tgt; n_fs = 0;
        end else begin
          n_pend = 1; n_pa = m_tgt; n_ps = 0;
        end
      end
    end
    pend <= n_pend; fly <= n_fly; pstale <= n_ps; fstale <= n_fs;
    paddr <= n_pa; faddr <= n_fa; pc <= n_pc;
  end

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("req", 32'(bus.instr_req_o), 32'(e_req));
    cmp("busy", 32'(bus.busy_o), 32'(e_busy));
    cmp("fvalid", 32'(bus.fifo_valid_o), 32'(m_push));
    cmp("fclear", 32'(bus.fifo_clear_o), 32'(bus.branch_i));
    if (e_req || rst) cmp("iaddr", bus.instr_addr_o, e_addr);
    if (m_push) begin
      cmp("faddr", bus.fifo_addr_o, faddr);
      cmp("frdata", bus.fifo_rdata_o, bus.instr_rdata_i);
    end
  end

  task automatic drv(input logic r, input logic rq, input logic br,
                     input logic [31:0] a, input logic g, input logic rv,
                     input logic [31:0] rd, input logic rdy);
    @(posedge clk);
    #1;
    rst                = r;
    bus.req_i          = rq;
    bus.branch_i       = br;
    bus.addr_i         = a;
    bus.instr_gnt_i    = g;
    bus.instr_rvalid_i = rv;
    bus.instr_rdata_i  = rd;
    bus.fifo_ready_i   = rdy;
    #2;
  endtask

  initial begin
    bus.req_i = 0; bus.branch_i = 0; bus.addr_i = 0;
    bus.instr_gnt_i = 0; bus.instr_rvalid_i = 0;
    bus.instr_rdata_i = 0; bus.fifo_ready_i = 0;
`ifdef IBEX_PREFETCH_ERR_EN
    bus.instr_err_i = 0;
`endif
    drv(1, 1, 0, 0, 0, 0, 0, 1);
    cmp("L_rst_req", 32'(bus.instr_req_o), 0);
    cmp("L_rst_busy", 32'(bus.busy_o), 0);
    cmp("L_rst_addr", bus.instr_addr_o, 0);
    // unaligned start
    drv(0, 1, 1, 32'h102, 1, 0, 0, 1);
    cmp("L_start_addr", bus.instr_addr_o, 32'h100);
    cmp("L_model_addr", e_addr, 32'h100);
    cmp("L_start_clr", 32'(bus.fifo_clear_o), 1);
    drv(0, 1, 0, 0, 0, 1, 32'hDEADBEEF, 1);
    cmp("L_push1_v", 32'(bus.fifo_valid_o), 1);
    cmp("L_push1_a", bus.fifo_addr_o, 32'h102);
    cmp("L_push1_d", bus.fifo_rdata_o, 32'hDEADBEEF);
    cmp("L_next_a", bus.instr_addr_o, 32'h104);
    // grant stall
    repeat (2) begin
      drv(0, 1, 0, 0, 0, 0, 0, 1);
      cmp("L_stall_a", bus.instr_addr_o, 32'h104);
      cmp("L_stall_busy", 32'(bus.busy_o), 1);
    end
    drv(0, 1, 0, 0, 1, 0, 0, 1);
    cmp("L_stall_g", bus.instr_addr_o, 32'h104);
    // abort in WAIT_RVALID
    drv(0, 1, 1, 32'h200, 0, 0, 0, 1);
    cmp("L_abort_req", 32'(bus.instr_req_o), 0);
    drv(0, 1, 0, 0, 1, 1, 32'h11111111, 1);
    cmp("L_abort_drop", 32'(bus.fifo_valid_o), 0);
    cmp("L_abort_a", bus.instr_addr_o, 32'h200);
    // backpressure
    drv(0, 1, 0, 0, 0, 1, 32'h22222222, 0);
    cmp("L_bp_push", bus.fifo_addr_o, 32'h200);
    cmp("L_bp_req", 32'(bus.instr_req_o), 0);
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    cmp("L_bp_idle", 32'(bus.busy_o), 0);
    drv(0, 1, 0, 0, 1, 0, 0, 1);
    cmp("L_bp_resume", bus.instr_addr_o, 32'h204);
    // branch with rvalid, then req_i falls
    drv(0, 1, 1, 32'h300, 1, 1, 32'h33333333, 1);
    cmp("L_brv_drop", 32'(bus.fifo_valid_o), 0);
    cmp("L_brv_a", bus.instr_addr_o, 32'h300);
    drv(0, 0, 0, 0, 0, 1, 32'h44444444, 1);
    cmp("L_fall_a", bus.fifo_addr_o, 32'h300);
    cmp("L_fall_req", 32'(bus.instr_req_o), 0);
    drv(0, 0, 0, 0, 0, 1, 32'h55555555, 1);
    cmp("L_stray", 32'(bus.fifo_valid_o), 0);
    // wrap
    drv(0, 1, 1, 32'hFFFFFFFC, 1, 0, 0, 1);
    drv(0, 1, 0, 0, 0, 1, 32'h66666666, 1);
    cmp("L_wrap_push", bus.fifo_addr_o, 32'hFFFFFFFC);
    cmp("L_wrap_a", bus.instr_addr_o, 32'h0);
    drv(0, 1, 0, 0, 1, 0, 0, 1);
    drv(0, 1, 0, 0, 0, 1, 32'h77777777, 1);
    cmp("L_w4", bus.instr_addr_o, 32'h4);
    // branch while waiting for grant
    drv(0, 1, 1, 32'h402, 0, 0, 0, 1);
    cmp("L_wg_hold", bus.instr_addr_o, 32'h4);
    drv(0, 1, 0, 0, 1, 0, 0, 1);
    drv(0, 1, 0, 0, 1, 1, 32'h88888888, 1);
    cmp("L_wg_drop", 32'(bus.fifo_valid_o), 0);
    cmp("L_wg_a", bus.instr_addr_o, 32'h400);
    drv(0, 1, 0, 0, 1, 1, 32'h99999999, 1);
    cmp("L_wg_push", bus.fifo_addr_o, 32'h402);
    cmp("L_wg_next", bus.instr_addr_o, 32'h404);
    // reset mid-transaction
    drv(1, 1, 0, 0, 0, 0, 0, 1);
    cmp("L_mrst_req", 32'(bus.instr_req_o), 0);
    cmp("L_mrst_busy", 32'(bus.busy_o), 0);
    drv(1, 1, 0, 0, 0, 1, 32'hAAAAAAAA, 1);
    cmp("L_mrst_rv", 32'(bus.fifo_valid_o), 0);
    drv(0, 1, 0, 0, 0, 1, 32'hBBBBBBBB, 1);
    cmp("L_boot_v", 32'(bus.fifo_valid_o), 0);
    cmp("L_boot_a", bus.instr_addr_o, 32'h80);
    drv(0, 1, 0, 0, 1, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1, 32'hCCCCCCCC, 1);
    cmp("L_boot_push", bus.fifo_addr_o, 32'h80);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
